// File: rtl/pipe_fifo_if.sv
// Producer/consumer bundle for pipe_fifo. The master modport is the
// environment side and the slave modport is the FIFO side.
interface pipe_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;
  logic [WIDTH-1:0] odata;
  logic             ovalid;
  logic             oready;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output idata, ivalid, oready,
    input  iready, odata, ovalid, count, almost_full, almost_empty
  );

  modport slave (
    input  idata, ivalid, oready,
    output iready, odata, ovalid, count, almost_full, almost_empty
  );
endinterface

// File: rtl/pipe_fifo.sv
// Synchronous FIFO with registered handshake and status outputs. Storage is
// a plain register array; count, pointers and flags are reset/flushed.
module pipe_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 7,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  pipe_fifo_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             iready_q, iready_d;
  logic             ovalid_q, ovalid_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             push, pop;

  // Handshake: a word transfers on a rising edge when valid and ready are both
  // high; ready never looks at valid, and a raised ovalid holds with stable
  // odata until it is popped, flushed or reset.
  assign push = bus.ivalid && iready_q && !flush;
  assign pop  = ovalid_q && bus.oready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    // Status flags follow the next-state count so they move with count.
    iready_d = (count_d < DEPTH_C);
    ovalid_d = (count_d != '0);
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      iready_q <= 1'b1;
      ovalid_q <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      iready_q <= iready_d;
      ovalid_q <= ovalid_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Data storage is deliberately left out of reset and flush.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.idata;
  end

  assign bus.iready       = iready_q;
  assign bus.ovalid       = ovalid_q;
  assign bus.odata        = mem_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_pipe_fifo.sv
// Directed bench for pipe_fifo (WIDTH=8, DEPTH=7, AF=6, AE=1) with a queue
// of expected words and per-cycle checks of every output.
module tb_pipe_fifo;
  logic clock;
  logic reset;
  logic flush;
  int   total;
  int   bad;
  logic [7:0] exp_q[$];

  pipe_fifo_if #(.WIDTH(8), .DEPTH(7)) f ();

  pipe_fifo #(.WIDTH(8), .DEPTH(7), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (f)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, ".count"},  32'(f.count), 32'(n));
    chk({tag, ".iready"}, 32'(f.iready), 32'(n < 7));
    chk({tag, ".ovalid"}, 32'(f.ovalid), 32'(n > 0));
    chk({tag, ".afull"},  32'(f.almost_full), 32'(n >= 6));
    chk({tag, ".aempty"}, 32'(f.almost_empty), 32'(n <= 1));
    if (n > 0) chk({tag, ".odata"}, 32'(f.odata), 32'(exp_q[0]));
  endtask

  // driver: inputs are applied 1 time unit after an edge, outputs checked
  // 1 time unit after the following edge
  task automatic cycle(input string tag, input logic vi, input logic [7:0] di,
                       input logic ro, input logic fl);
    logic do_push, do_pop;
    f.ivalid = vi;
    f.idata  = di;
    f.oready = ro;
    flush    = fl;
    do_push  = vi && (exp_q.size() < 7) && !fl;
    do_pop   = ro && (exp_q.size() > 0) && !fl;
    @(posedge clock);
    #1;
    if (fl) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(di);
    end
    check_state(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    f.ivalid = 1'b0;
    f.idata  = 8'h00;
    f.oready = 1'b0;
    #12;
    check_state("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // fill: 0x01..0x09 offered, only 0x01..0x07 fit
    for (int k = 1; k <= 9; k++) cycle("fill", 1'b1, 8'(k), 1'b0, 1'b0);
    chk("fill.full_count", 32'(f.count), 32'd7);
    chk("fill.full_iready", 32'(f.iready), 32'd0);

    // drain: 0x01..0x07 presented on consecutive cycles
    for (int k = 1; k <= 7; k++) begin
      chk("drain.head", 32'(f.odata), 32'(k));
      cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain.ovalid_end", 32'(f.ovalid), 32'd0);
    chk("drain.aempty_end", 32'(f.almost_empty), 32'd1);

    // steady state at count 3 across the pointer wrap
    for (int k = 0; k < 3; k++) cycle("pre3", 1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    for (int k = 3; k < 23; k++) cycle("stream", 1'b1, 8'(8'h10 + k), 1'b1, 1'b0);
    chk("stream.count", 32'(f.count), 32'd3);
    chk("stream.head", 32'(f.odata), 32'h24);
    for (int k = 0; k < 3; k++) cycle("post3", 1'b0, 8'h00, 1'b1, 1'b0);

    // single word with consumer ready: one cycle latency, then popped
    cycle("a5.push", 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("a5.odata", 32'(f.odata), 32'hA5);
    chk("a5.ovalid", 32'(f.ovalid), 32'd1);
    cycle("a5.pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5.gone", 32'(f.ovalid), 32'd0);

    // flush at count 4 overrides a simultaneous push and pop
    for (int k = 0; k < 4; k++) cycle("pre4", 1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h99, 1'b1, 1'b1);
    chk("flush.count", 32'(f.count), 32'd0);
    chk("flush.iready", 32'(f.iready), 32'd1);
    cycle("p3c", 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("p3c.odata", 32'(f.odata), 32'h3C);
    cycle("p3c.pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset between edges at count 5
    for (int k = 0; k < 5; k++) cycle("pre5", 1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
    f.ivalid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_state("areset");
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_state("areset.hold");
    cycle("p11", 1'b1, 8'h11, 1'b0, 1'b0);
    chk("p11.odata", 32'(f.odata), 32'h11);
    cycle("p11.pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
